// File: rtl/ov7670_stream_gen.sv
// OV7670 sensor-pin emulator: PCLK/VSYNC/HREF/D with QVGA RGB565 test patterns.
// Optional per-frame CRC-16-CCITT over HREF bytes when OV7670_GEN_CRC_EN is defined.
module ov7670_stream_gen #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP        = 17,
  parameter int V_FP        = 10
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        ov_pclk,
  output logic        ov_vsync,
  output logic        ov_href,
  output logic [7:0]  ov_d,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [15:0] crc_out
);
  localparam logic [15:0] SLOT_LAST  = 16'(2*H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] DATA_SLOTS = 16'(2*H_ACTIVE);
  localparam logic [15:0] BAR_LAST   = 16'(H_ACTIVE/8 - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  state_t      state_q, state_d, nstate;
  logic [15:0] slot_q, slot_d, nslot;
  logic [15:0] line_q, line_d, nline, line_last;
  logic        pclk_q, pclk_d, en_q, en_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] solid_q, solid_d;
  logic        vsync_q, vsync_d, href_q, href_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]  d_q, d_d, lo_q, lo_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] x_q, x_d, bar_cnt_q, bar_cnt_d, ramp_q, ramp_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic        start_c, end_frame_c, data_c;
  logic [7:0]  byte_c;
  logic [15:0] cx, cbc, pix_c;
  logic [2:0]  cbi;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      S_VSYNC:  line_last = 16'(VSYNC_LINES - 1);
      S_VBP:    line_last = 16'(V_BP - 1);
      S_ACTIVE: line_last = 16'(V_ACTIVE - 1);
      default:  line_last = 16'(V_FP - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;  slot_d = slot_q;  line_d = line_q;
    pclk_d = ~pclk_q;
    en_d = pclk_q ? en_q : enable;   // sampled on the edge that raises PCLK
    pat_d = pat_q;  solid_d = solid_q;
    vsync_d = vsync_q;  href_d = href_q;  d_d = d_q;  lo_d = lo_q;
    busy_d = busy_q;  done_d = 1'b0;  fcnt_d = fcnt_q;
    x_d = x_q;  bar_cnt_d = bar_cnt_q;  bar_idx_d = bar_idx_q;  ramp_d = ramp_q;
    nstate = state_q;  nslot = slot_q;  nline = line_q;
    start_c = 1'b0;  end_frame_c = 1'b0;  data_c = 1'b0;  byte_c = 8'h00;
    cx = x_q;  cbc = bar_cnt_q;  cbi = bar_idx_q;  pix_c = 16'h0000;
    if (pclk_q) begin
      if (state_q == S_IDLE) begin
        start_c = en_q;
      end else if (slot_q == SLOT_LAST) begin
        nslot = 16'h0000;
        if (line_q == line_last) begin
          nline = 16'h0000;
          case (state_q)
            S_VSYNC:  nstate = S_VBP;
            S_VBP:    nstate = S_ACTIVE;
            S_ACTIVE: nstate = S_VFP;
            default: begin
              end_frame_c = 1'b1;
              nstate      = S_IDLE;
              start_c     = en_q;
            end
          endcase
        end else begin
          nline = line_q + 16'h0001;
        end
      end else begin
        nslot = slot_q + 16'h0001;
      end
      if (start_c) begin
        nstate = S_VSYNC;  nslot = 16'h0000;  nline = 16'h0000;
        pat_d = pattern_sel;  solid_d = solid_rgb;  ramp_d = 16'h0000;
      end
      if (end_frame_c) begin
        done_d = 1'b1;
        fcnt_d = fcnt_q + 16'h0001;
      end
      data_c = (nstate == S_ACTIVE) && (nslot < DATA_SLOTS);
      if (data_c && !nslot[0]) begin
        // line start rewinds the column counters before this pixel is formed
        if (nslot == 16'h0000) begin
          cx = 16'h0000;  cbc = 16'h0000;  cbi = 3'd0;
        end
        case (pat_q)
          2'd0:    pix_c = bar_color(cbi);
          2'd1:    pix_c = ramp_q;
          2'd2:    pix_c = solid_q;
          default: pix_c = {nline[7:0], cx[7:0]} ^ {fcnt_q[7:0], 8'h00};
        endcase
        byte_c = pix_c[15:8];
        lo_d   = pix_c[7:0];
        x_d    = cx + 16'h0001;
        ramp_d = ramp_q + 16'h0001;
        if (cbc == BAR_LAST) begin
          bar_cnt_d = 16'h0000;  bar_idx_d = cbi + 3'd1;
        end else begin
          bar_cnt_d = cbc + 16'h0001;  bar_idx_d = cbi;
        end
      end else if (data_c) begin
        byte_c = lo_q;
      end
      state_d = nstate;  slot_d = nslot;  line_d = nline;
      vsync_d = (nstate == S_VSYNC);
      href_d  = data_c;
      d_d     = byte_c;
      busy_d  = (nstate != S_IDLE);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;  slot_q <= '0;  line_q <= '0;
      pclk_q <= 1'b0;  en_q <= 1'b0;  pat_q <= '0;  solid_q <= '0;
      vsync_q <= 1'b0;  href_q <= 1'b0;  d_q <= '0;  lo_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  fcnt_q <= '0;
      x_q <= '0;  bar_cnt_q <= '0;  bar_idx_q <= '0;  ramp_q <= '0;
    end else begin
      state_q <= state_d;  slot_q <= slot_d;  line_q <= line_d;
      pclk_q <= pclk_d;  en_q <= en_d;  pat_q <= pat_d;  solid_q <= solid_d;
      vsync_q <= vsync_d;  href_q <= href_d;  d_q <= d_d;  lo_q <= lo_d;
      busy_q <= busy_d;  done_q <= done_d;  fcnt_q <= fcnt_d;
      x_q <= x_d;  bar_cnt_q <= bar_cnt_d;  bar_idx_q <= bar_idx_d;  ramp_q <= ramp_d;
    end
  end

`ifdef OV7670_GEN_CRC_EN
  logic [15:0] crc_q, crc_d, crc_out_q, crc_out_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = (r[15] ^ b[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    crc_out_d = crc_out_q;
    if (end_frame_c) crc_out_d = crc_q;
    if (start_c) crc_d = 16'hFFFF;
    else if (data_c) crc_d = crc_step(crc_q, byte_c);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      crc_q <= 16'hFFFF;
      crc_out_q <= '0;
    end else begin
      crc_q <= crc_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign crc_out = crc_out_q;
`else
  assign crc_out = 16'h0000;
`endif

  assign ov_pclk     = pclk_q;
  assign ov_vsync    = vsync_q;
  assign ov_href     = href_q;
  assign ov_d        = d_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = fcnt_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen on a reduced frame geometry.
module tb_ov7670_stream_gen;
  localparam int H = 64, V = 6, HB = 16, VS = 2, VBP = 2, VFP = 2;
  localparam int LINE_CYC  = (2*H + HB) * 2;
  localparam int FRAME_CYC = (VS + VBP + V + VFP) * LINE_CYC;

  logic        aclk = 1'b0, areset = 1'b1, enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        ov_pclk, ov_vsync, ov_href, busy, frame_done;
  logic [7:0]  ov_d;
  logic [15:0] frame_count, crc_out;

  ov7670_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB),
                      .VSYNC_LINES(VS), .V_BP(VBP), .V_FP(VFP)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .ov_pclk(ov_pclk), .ov_vsync(ov_vsync), .ov_href(ov_href),
    .ov_d(ov_d), .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .crc_out(crc_out));

  always #5 aclk = ~aclk;

  int nchk = 0, nerr = 0, cyc = 0;
  initial forever begin @(posedge aclk); cyc++; end

  // receiver: samples once per slot while PCLK is high
  logic [15:0] pix [0:V-1][0:H-1];
  int vs_rise_cnt = 0, vs_rise_cyc = 0, vs_len = 0, first_href = 0, href_cnt = 0;
  int last_rise = 0, bytecnt = 0, len_err = 0, sp_err = 0;
  logic [7:0] hi = 8'h00;
  logic pvs = 1'b0, phref = 1'b0;
  initial forever begin
    @(negedge aclk);
    if (ov_pclk) begin
      if (ov_vsync && !pvs) begin
        vs_rise_cnt++; vs_rise_cyc = cyc; href_cnt = 0; len_err = 0; sp_err = 0;
      end
      if (!ov_vsync && pvs) vs_len = cyc - vs_rise_cyc;
      if (ov_href && !phref) begin
        if (href_cnt == 0) first_href = cyc - vs_rise_cyc;
        else if (cyc - last_rise != LINE_CYC) sp_err++;
        last_rise = cyc; bytecnt = 0;
      end
      if (ov_href) begin
        if (bytecnt % 2 == 0) hi = ov_d;
        else if (href_cnt < V && bytecnt < 2*H) pix[href_cnt][bytecnt/2] = {hi, ov_d};
        bytecnt++;
      end
      if (!ov_href && phref) begin
        if (bytecnt != 2*H) len_err++;
        href_cnt++;
      end
      pvs = ov_vsync; phref = ov_href;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    nchk++; nerr++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  task automatic wait_vs(input int n0);
    int k = 0;
    while (vs_rise_cnt == n0 && k < 2*FRAME_CYC) begin @(negedge aclk); k++; end
    if (vs_rise_cnt == n0) timeout("wait_vsync");
  endtask

  task automatic wait_done(output int t);
    int k = 0;
    do begin @(negedge aclk); k++; end while (!frame_done && k < 2*FRAME_CYC + 100);
    if (!frame_done) timeout("wait_frame_done");
    t = cyc;
  endtask

  task automatic wait_line(input int n);
    int k = 0;
    while (!(href_cnt >= n && ov_href) && k < 2*FRAME_CYC) begin @(negedge aclk); k++; end
    if (!(href_cnt >= n && ov_href)) timeout("wait_line");
  endtask

  task automatic run_frame(input logic [1:0] p, input logic [15:0] s);
    int t;
    pattern_sel = p; solid_rgb = s; enable = 1'b1;
    wait_vs(vs_rise_cnt);
    enable = 1'b0;
    wait_done(t);
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  typedef struct { logic [1:0] pat; logic [15:0] solid; int x; int y; logic [15:0] exp; } vec_t;
  vec_t vt [18];

  initial begin
    int t1, t2, bad, fc_first;
    logic [15:0] crc_exp;
    // ramp, bars, xor (frame_count=2 during that frame), solid
    vt[0]  = '{2'd1, 16'h0, 1, 0, 16'h0001};  vt[1]  = '{2'd1, 16'h0, 0, 0, 16'h0000};
    vt[2]  = '{2'd1, 16'h0, 63, 0, 16'h003F}; vt[3]  = '{2'd1, 16'h0, 0, 1, 16'h0040};
    vt[4]  = '{2'd1, 16'h0, 63, 5, 16'h017F};
    vt[5]  = '{2'd0, 16'h0, 7, 0, 16'hFFFF};  vt[6]  = '{2'd0, 16'h0, 8, 0, 16'hFFE0};
    vt[7]  = '{2'd0, 16'h0, 16, 0, 16'h07FF}; vt[8]  = '{2'd0, 16'h0, 24, 0, 16'h07E0};
    vt[9]  = '{2'd0, 16'h0, 32, 0, 16'hF81F}; vt[10] = '{2'd0, 16'h0, 47, 0, 16'hF800};
    vt[11] = '{2'd0, 16'h0, 48, 0, 16'h001F}; vt[12] = '{2'd0, 16'h0, 56, 0, 16'h0000};
    vt[13] = '{2'd0, 16'h0, 63, 5, 16'h0000};
    vt[14] = '{2'd3, 16'h0, 0, 0, 16'h0200};  vt[15] = '{2'd3, 16'h0, 5, 3, 16'h0105};
    vt[16] = '{2'd2, 16'hBEEF, 0, 0, 16'hBEEF}; vt[17] = '{2'd2, 16'hBEEF, 63, 5, 16'hBEEF};

    #2;
    chk("rst_pclk", ov_pclk, 0); chk("rst_vsync", ov_vsync, 0); chk("rst_href", ov_href, 0);
    chk("rst_d", ov_d, 0); chk("rst_busy", busy, 0); chk("rst_done", frame_done, 0);
    chk("rst_fcnt", frame_count, 0); chk("rst_crc", crc_out, 0);
    @(negedge aclk); #1 areset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      if (i == 0 || vt[i].pat != vt[i-1].pat) begin
        run_frame(vt[i].pat, vt[i].solid);
        chk("href_lines", href_cnt, V);
        chk("href_len_errs", len_err, 0);
        chk("href_spacing_errs", sp_err, 0);
        if (i == 0) begin
          chk("vsync_len", vs_len, VS*LINE_CYC);
          chk("first_href", first_href, (VS+VBP)*LINE_CYC);
        end
      end
      chk($sformatf("pix_p%0d_x%0d_y%0d", vt[i].pat, vt[i].x, vt[i].y), pix[vt[i].y][vt[i].x], vt[i].exp);
    end
    chk("fcnt_after_table", frame_count, 4);

    // asynchronous reset in the middle of an active line
    enable = 1'b1; pattern_sel = 2'd1;
    wait_vs(vs_rise_cnt);
    wait_line(3);
    enable = 1'b0;
    #1 areset = 1'b1;
    #1;
    chk("mid_rst_pclk", ov_pclk, 0); chk("mid_rst_vsync", ov_vsync, 0);
    chk("mid_rst_href", ov_href, 0); chk("mid_rst_d", ov_d, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_fcnt", frame_count, 0);
    chk("mid_rst_crc", crc_out, 0);
    repeat (3) @(negedge aclk);
    #1 areset = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge aclk);
      if (ov_pclk !== (k % 2 == 0) || ov_vsync || ov_href || busy) bad++;
    end
    chk("idle_pclk_toggle", bad, 0);

    // start latency: enable seen on the PCLK-rising edge, VSYNC on the next
    if (ov_pclk) @(negedge aclk);
    enable = 1'b1; pattern_sel = 2'd1;
    @(negedge aclk);
    chk("start_vsync_early", ov_vsync, 0);
    @(negedge aclk);
    chk("start_vsync", ov_vsync, 1); chk("start_pclk_low", ov_pclk, 0); chk("start_busy", busy, 1);

    // enable dropped mid-ACTIVE: frame completes, no new VSYNC
    wait_line(3);
    enable = 1'b0;
    wait_done(t1);
    chk("drop_fcnt", frame_count, 1); chk("drop_busy_fall", busy, 0);
    bad = vs_rise_cnt;
    repeat (2*LINE_CYC) @(negedge aclk);
    chk("drop_no_vsync", vs_rise_cnt, bad); chk("drop_idle_busy", busy, 0);

    // pattern inputs changed mid-frame take effect only on the next frame
    pattern_sel = 2'd2; solid_rgb = 16'h1234; enable = 1'b1;
    wait_vs(vs_rise_cnt);
    wait_line(2);
    pattern_sel = 2'd0; solid_rgb = 16'hFFFF;
    wait_done(t1);
    enable = 1'b0;
    bad = 0;
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) if (pix[y][x] !== 16'h1234) bad++;
    chk("latched_solid_bad_pix", bad, 0);
    chk("latched_fcnt", frame_count, 2);
    wait_done(t1);
    chk("next_bars_x0", pix[0][0], 16'hFFFF);
    chk("next_bars_x40_y2", pix[2][40], 16'hF800);
    chk("next_bars_x63_y5", pix[5][63], 16'h0000);

    // continuous frames, solid zero, CRC
    @(negedge aclk); #1 areset = 1'b1;
    @(negedge aclk); #1 areset = 1'b0;
    pattern_sel = 2'd2; solid_rgb = 16'h0000; enable = 1'b1;
    wait_done(t1);
    fc_first = frame_count;
    wait_done(t2);
    chk("frame_period", t2 - t1, FRAME_CYC);
    chk("cont_fcnt_first", fc_first, 1);
    chk("cont_fcnt", frame_count, 2);
    crc_exp = 16'hFFFF;
    for (int k = 0; k < V*2*H; k++) crc_exp = crc_upd(crc_exp, 8'h00);
`ifndef OV7670_GEN_CRC_EN
    crc_exp = 16'h0000;
`endif
    chk("crc_out", crc_out, crc_exp);
    enable = 1'b0;
    wait_done(t1);
    chk("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
